// File: rtl/regfile_wb_scheduler_pkg.sv
// Purpose : shared defaults and requester indices for the regfile writeback scheduler.
// Latency : n/a (constants and a helper function only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREQ   = 3;

  // Writeback requester slots on the shared write port.
  localparam int REQ_ALU    = 0;
  localparam int REQ_LSU    = 1;
  localparam int REQ_MULDIV = 2;

  // Width of an index into n requesters (at least 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Purpose : bundles the writeback, register-file write, issue and hazard-query signals.
// Latency : n/a (wiring only).
// Backpressure: wb_ready per requester; iss_ready blocks dispatch on WAW.
// Ports   : slave = scheduler side, master = execution units / issue / regfile side.
interface regfile_wb_scheduler_if
  import regfile_pkg::*;
#(
  parameter int XLEN_P   = XLEN,
  parameter int REG_AW_P = REG_AW,
  parameter int NREQ_P   = NREQ
);

  logic [NREQ_P-1:0]          wb_valid;
  logic [NREQ_P-1:0]          wb_ready;
  logic [NREQ_P*REG_AW_P-1:0] wb_rd;
  logic [NREQ_P*XLEN_P-1:0]   wb_data;
  logic [REG_AW_P-1:0]        rf_rd;
  logic [XLEN_P-1:0]          rf_data;
  logic                       iss_valid;
  logic [REG_AW_P-1:0]        iss_rd;
  logic                       iss_ready;
  logic [REG_AW_P-1:0]        q_rs1;
  logic [REG_AW_P-1:0]        q_rs2;
  logic                       hz_rs1;
  logic                       hz_rs2;
  logic                       err_wb_nobusy;

  modport slave (
    input  wb_valid, wb_rd, wb_data, iss_valid, iss_rd, q_rs1, q_rs2,
    output wb_ready, rf_rd, rf_data, iss_ready, hz_rs1, hz_rs2, err_wb_nobusy
  );

  modport master (
    output wb_valid, wb_rd, wb_data, iss_valid, iss_rd, q_rs1, q_rs2,
    input  wb_ready, rf_rd, rf_data, iss_ready, hz_rs1, hz_rs2, err_wb_nobusy
  );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Purpose : round-robin arbiter; first requester at or above ptr (wrapping) wins.
// Latency : 0 cycles (purely combinational).
// Backpressure: losers simply see no grant and must hold their request.
// Ports   : req[N], ptr -> one-hot gnt[N], encoded gnt_idx (0 when no grant).
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N  = NREQ,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      // ptr is always < N, so one subtraction is enough to wrap.
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found      = 1'b1;
        gnt[j]     = 1'b1;
        gnt_idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Purpose : shares the single regfile write port among NREQ writeback sources
//           (round-robin) and keeps a busy scoreboard for RAW/WAW detection.
// Latency : 0 cycles for grant, rf write, iss_ready and hazards; state updates at the edge.
// Backpressure: one wb_ready per cycle; requesters hold until granted, nothing is buffered.
// Ports   : clk, rst (async, active-low), bus (regfile_wb_scheduler_if.slave).
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int XLEN_P   = XLEN,
  parameter int REG_AW_P = REG_AW,
  parameter int NREQ_P   = NREQ
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_scheduler_if.slave bus
);

  localparam int PW   = idx_w(NREQ_P);
  localparam int NREG = 2 ** REG_AW_P;

  logic [PW-1:0]       rr_ptr;
  logic [NREG-1:0]     busy;
  logic                err_q;
  logic [NREQ_P-1:0]   gnt;
  logic [PW-1:0]       gnt_idx;
  logic                grant;
  logic [REG_AW_P-1:0] sel_rd;
  logic [XLEN_P-1:0]   sel_data;
  logic                iss_rdy;

  rr_arbiter #(.N(NREQ_P), .PW(PW)) u_arb (
    .req     (bus.wb_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Reset forces the port idle, overriding whatever the arbiter picked.
  assign grant = rst & (|gnt);

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ_P; i++) begin
      if (rst && gnt[i]) begin
        sel_rd   = sel_rd   | bus.wb_rd[i*REG_AW_P +: REG_AW_P];
        sel_data = sel_data | bus.wb_data[i*XLEN_P +: XLEN_P];
      end
    end
  end

  // Ready looks only at registered busy bits: a same-cycle clear does not
  // open the gate, so set and clear never collide on one bit.
  assign iss_rdy = ~busy[bus.iss_rd] | (bus.iss_rd == '0);

  assign bus.wb_ready      = {NREQ_P{rst}} & gnt;
  assign bus.rf_rd         = sel_rd;
  assign bus.rf_data       = sel_data;
  assign bus.iss_ready     = iss_rdy;
  assign bus.hz_rs1        = busy[bus.q_rs1] & (bus.q_rs1 != '0);
  assign bus.hz_rs2        = busy[bus.q_rs2] & (bus.q_rs2 != '0);
  assign bus.err_wb_nobusy = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      busy   <= '0;
      err_q  <= 1'b0;
    end else begin
      if (grant) begin
        rr_ptr <= (gnt_idx == PW'(NREQ_P - 1)) ? '0 : gnt_idx + PW'(1);
      end
      // Writebacks to x0 are accepted but leave the scoreboard alone.
      if (grant && sel_rd != '0) begin
        busy[sel_rd] <= 1'b0;
        if (!busy[sel_rd]) err_q <= 1'b1;
      end
      if (bus.iss_valid && iss_rdy && bus.iss_rd != '0) begin
        busy[bus.iss_rd] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  typedef struct {
    logic [2:0]  rdy;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        irdy;
    logic        hz1;
    logic        hz2;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_q[$];

  // Reference state: round-robin start point, busy set, sticky error.
  int mptr;
  bit mbusy [32];
  bit merr;

  regfile_wb_scheduler_if #(.XLEN_P(32), .REG_AW_P(5), .NREQ_P(3)) bus ();

  regfile_wb_scheduler #(.XLEN_P(32), .REG_AW_P(5), .NREQ_P(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mptr = 0;
    merr = 1'b0;
    for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
  endfunction

  // Lowest valid index at or after the start point; otherwise lowest overall.
  function automatic int model_grant(input logic [2:0] v);
    for (int i = mptr; i < 3; i++) if (v[i]) return i;
    for (int i = 0; i < mptr; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [14:0] prd(input logic [4:0] a, b, c);
    return {c, b, a};
  endfunction

  function automatic logic [95:0] pdat(input logic [31:0] a, b, c);
    return {c, b, a};
  endfunction

  // Drive one cycle of inputs, push the expected outputs, advance the model.
  task automatic cycle(input logic [2:0] vld, input logic [14:0] rds, input logic [95:0] dats,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] q1, input logic [4:0] q2, output int g);
    exp_t        e;
    logic [14:0] rv;
    logic [95:0] dv;
    @(negedge clk);
    bus.wb_valid  = vld;
    bus.wb_rd     = rds;
    bus.wb_data   = dats;
    bus.iss_valid = iv;
    bus.iss_rd    = ird;
    bus.q_rs1     = q1;
    bus.q_rs2     = q2;
    #1;
    rv = rds;
    dv = dats;
    g  = model_grant(vld);
    e.rdy  = '0;
    e.rd   = '0;
    e.data = '0;
    if (g >= 0) begin
      e.rdy[g] = 1'b1;
      e.rd     = rv[g*5 +: 5];
      e.data   = dv[g*32 +: 32];
    end
    e.irdy = !mbusy[ird] || (ird == 0);
    e.hz1  = mbusy[q1] && (q1 != 0);
    e.hz2  = mbusy[q2] && (q2 != 0);
    e.err  = merr;
    exp_q.push_back(e);
    if (g >= 0) begin
      mptr = (g + 1) % 3;
      if (e.rd != 0) begin
        if (!mbusy[e.rd]) merr = 1'b1;
        mbusy[e.rd] = 1'b0;
      end
    end
    if (iv && e.irdy && ird != 0) mbusy[ird] = 1'b1;
  endtask

  // Monitor: samples just before each rising edge, after inputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wb_ready",      32'(bus.wb_ready),      32'(e.rdy));
        chk("rf_rd",         32'(bus.rf_rd),         32'(e.rd));
        chk("rf_data",       bus.rf_data,            e.data);
        chk("iss_ready",     32'(bus.iss_ready),     32'(e.irdy));
        chk("hz_rs1",        32'(bus.hz_rs1),        32'(e.hz1));
        chk("hz_rs2",        32'(bus.hz_rs2),        32'(e.hz2));
        chk("err_wb_nobusy", 32'(bus.err_wb_nobusy), 32'(e.err));
      end
    end
  end

  initial begin
    int          g;
    bit          pend [3];
    logic [4:0]  prd_r [3];
    logic [31:0] pdat_r [3];
    logic [14:0] rds;
    logic [95:0] dats;
    logic [2:0]  vld;
    logic        iv;
    logic [4:0]  ird;
    int          bl[$];

    rst           = 1'b0;
    bus.wb_valid  = '0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.q_rs1     = '0;
    bus.q_rs2     = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Idle after reset: iss_ready high for every destination, no hazards.
    for (int i = 0; i < 32; i++)
      cycle(3'b000, '0, '0, 1'b0, 5'(i), 5'(i), 5'(31 - i), g);

    // All requesters valid from ptr=0: grants rotate 0,1,2,0,1,2.
    for (int k = 0; k < 6; k++) begin
      cycle(3'b111, prd(0, 0, 0), pdat($urandom, $urandom, $urandom), 1'b0, 0, 0, 0, g);
      #1;
      chk("rr_sequence", 32'(bus.wb_ready), 32'(1) << (k % 3));
    end

    // Issue x5, then ALU writes it back; hz_rs1 tracks busy[5].
    cycle(3'b000, '0, '0, 1'b1, 5, 5, 0, g);
    cycle(3'b000, '0, '0, 1'b0, 0, 5, 0, g);
    cycle(3'b001, prd(5, 0, 0), pdat(32'hDEADBEEF, 0, 0), 1'b0, 0, 5, 0, g);
    cycle(3'b000, '0, '0, 1'b0, 0, 5, 0, g);

    // WAW: x7 busy blocks dispatch; LSU clears it in that same cycle.
    cycle(3'b000, '0, '0, 1'b1, 7, 7, 0, g);
    cycle(3'b010, prd(0, 7, 0), pdat(0, 32'h1234_5678, 0), 1'b1, 7, 7, 0, g);
    cycle(3'b000, '0, '0, 1'b0, 7, 7, 0, g);

    // x0 writeback is a harmless no-op; x9 writeback without busy is an error.
    cycle(3'b001, prd(0, 0, 0), pdat(32'hCAFE, 0, 0), 1'b0, 0, 0, 0, g);
    cycle(3'b000, '0, '0, 1'b0, 0, 0, 0, g);
    cycle(3'b010, prd(0, 9, 0), pdat(0, 32'h99, 0), 1'b0, 0, 9, 0, g);
    repeat (3) cycle(3'b000, '0, '0, 1'b0, 0, 0, 0, g);

    // Asynchronous reset with x3 and x12 busy and all requesters valid.
    cycle(3'b000, '0, '0, 1'b1, 3, 0, 0, g);
    cycle(3'b000, '0, '0, 1'b1, 12, 3, 12, g);
    @(negedge clk);
    bus.wb_valid  = 3'b111;
    bus.wb_rd     = prd(1, 2, 4);
    bus.wb_data   = pdat(1, 2, 3);
    bus.iss_valid = 1'b0;
    bus.q_rs1     = 3;
    bus.q_rs2     = 12;
    #1;
    chk("pre_rst_hz_rs1", 32'(bus.hz_rs1), 32'(mbusy[3]));
    chk("pre_rst_hz_rs2", 32'(bus.hz_rs2), 32'(mbusy[12]));
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_hz_rs1",   32'(bus.hz_rs1),        32'(mbusy[3]));
    chk("rst_hz_rs2",   32'(bus.hz_rs2),        32'(mbusy[12]));
    chk("rst_wb_ready", 32'(bus.wb_ready),      32'(0));
    chk("rst_rf_rd",    32'(bus.rf_rd),         32'(0));
    chk("rst_rf_data",  bus.rf_data,            32'(0));
    chk("rst_err",      32'(bus.err_wb_nobusy), 32'(merr));
    @(negedge clk);
    bus.wb_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    cycle(3'b111, prd(0, 0, 0), pdat(7, 8, 9), 1'b0, 0, 3, 12, g);
    #1;
    chk("post_rst_first_grant", 32'(bus.wb_ready), 32'(1) << REQ_ALU);

    // Randomized traffic: requesters hold until granted.
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    for (int c = 0; c < 500; c++) begin
      bl.delete();
      for (int r = 1; r < 16; r++) if (mbusy[r]) bl.push_back(r);
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 50) begin
          pend[i] = 1'b1;
          if (bl.size() > 0 && $urandom_range(0, 3) != 0)
            prd_r[i] = 5'(bl[$urandom_range(0, bl.size() - 1)]);
          else
            prd_r[i] = 5'($urandom_range(0, 15));
          pdat_r[i] = $urandom;
        end
      end
      vld  = {pend[2], pend[1], pend[0]};
      rds  = prd(prd_r[0], prd_r[1], prd_r[2]);
      dats = pdat(pdat_r[0], pdat_r[1], pdat_r[2]);
      iv   = 1'($urandom_range(0, 1));
      ird  = 5'($urandom_range(0, 15));
      for (int i = 0; i < 3; i++) if (pend[i] && prd_r[i] == ird) iv = 1'b0;
      cycle(vld, rds, dats, iv, ird, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), g);
      if (g >= 0) pend[g] = 1'b0;
    end

    repeat (2) @(negedge clk);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
